// File: rtl/st2bus_if.sv
// Stream-side and CL-bus-side signals of the st2bus packer, bundled for port hookup.
// Handshakes: a stream word moves on a rising clk edge where st_valid & st_ready; a CL moves on an edge where bus_en is 1 (bus_en already includes bus_ready).
interface st2bus_if #(
    parameter int ST  = 24,
    parameter int BUS = 512
);
    logic [ST-1:0]  st_data;
    logic           st_valid;
    logic           st_sop;
    logic           st_eop;
    logic           st_ready;
    logic [BUS-1:0] bus_data;
    logic           bus_en;
    logic           bus_ready;

    modport master (
        output st_data, st_valid, st_sop, st_eop, bus_ready,
        input  st_ready, bus_data, bus_en
    );

    modport slave (
        input  st_data, st_valid, st_sop, st_eop, bus_ready,
        output st_ready, bus_data, bus_en
    );
endinterface

// File: rtl/st2bus.sv
// Packs Avalon-ST frames into cache-line bus words: header {flag, length} on top, payload lowest word first.
// One accumulator plus one output register; a closed CL that cannot load waits in the accumulator (S_HOLD).
module st2bus #(
    parameter int BUS         = 512,
    parameter int BUS_HEAD    = 8,
    parameter int BUS_PAYLOAD = 504,
    parameter int ST          = 24,
    parameter int w_frm_cnt   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    st2bus_if.slave              io,
    output logic                 frm_done,
    output logic [w_frm_cnt-1:0] frm_cnt,
    output logic                 err_sop,
    output logic [1:0]           state_dbg
);
    localparam int WPC = BUS_PAYLOAD / ST;
    localparam int BPW = ST / 8;
    localparam int LW  = BUS_HEAD - 2;
    localparam int AW  = ST * WPC;
    localparam int CW  = $clog2(WPC + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_HOLD = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            ready_en_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   wcnt_q;
    logic            start_q;
    logic            hold_eop_q;
    logic [BUS-1:0]  out_q;
    logic            out_full_q;

    logic            accept, restart, take, close, can_load;
    logic [AW-1:0]   base_acc, ins_acc;
    logic [CW-1:0]   base_cnt;
    logic            base_start;
    logic            load_out, acc_en, acc_clr;

    logic [CW-1:0]          cl_words;
    logic                   cl_start, cl_eop;
    logic [AW-1:0]          cl_acc;
    logic [31:0]            cl_len;
    logic [BUS_PAYLOAD-1:0] cl_payload;
    logic [BUS-1:0]         cl_word;

    assign io.bus_en   = out_full_q & io.bus_ready;
    assign io.bus_data = out_q;
    assign can_load    = !out_full_q || io.bus_en;
    assign accept      = io.st_valid & io.st_ready;
    assign err_sop     = accept & io.st_sop & (state_q == S_FILL);
    assign frm_done    = io.bus_en & out_q[BUS-2];
    assign state_dbg   = state_q;

    // A sop always restarts the accumulator, whether it opens a frame or aborts a partial one.
    always_comb begin
        restart    = accept & io.st_sop;
        take       = accept & ((state_q == S_FILL) | io.st_sop);
        base_acc   = restart ? '0 : acc_q;
        base_cnt   = restart ? '0 : wcnt_q;
        base_start = restart | start_q;
        ins_acc    = base_acc;
        for (int k = 0; k < WPC; k++) begin
            if (base_cnt == CW'(k)) ins_acc[k*ST +: ST] = io.st_data;
        end
        close = take & ((base_cnt == CW'(WPC - 1)) | io.st_eop);
    end

    always_comb begin
        if (state_q == S_HOLD) begin
            cl_words = wcnt_q;
            cl_start = start_q;
            cl_eop   = hold_eop_q;
            cl_acc   = acc_q;
        end else begin
            cl_words = CW'(base_cnt + CW'(1));
            cl_start = base_start;
            cl_eop   = io.st_eop;
            cl_acc   = ins_acc;
        end
        cl_len              = 32'(int'(cl_words) * BPW);
        cl_payload          = '0;
        cl_payload[AW-1:0]  = cl_acc;
        cl_word             = {cl_start, cl_eop, cl_len[LW-1:0], cl_payload};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        acc_en      = 1'b0;
        acc_clr     = 1'b0;
        io.st_ready = ready_en_q & (state_q != S_HOLD);
        case (state_q)
            S_IDLE, S_FILL: begin
                if (take) begin
                    if (close && can_load) begin
                        load_out = 1'b1;
                        acc_clr  = 1'b1;
                        state_d  = io.st_eop ? S_IDLE : S_FILL;
                    end else begin
                        acc_en  = 1'b1;
                        state_d = close ? S_HOLD : S_FILL;
                    end
                end
            end
            S_HOLD: begin
                if (can_load) begin
                    load_out = 1'b1;
                    acc_clr  = 1'b1;
                    state_d  = hold_eop_q ? S_IDLE : S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            wcnt_q     <= '0;
            start_q    <= 1'b0;
            hold_eop_q <= 1'b0;
        end else if (acc_clr) begin
            acc_q   <= '0;
            wcnt_q  <= '0;
            start_q <= 1'b0;
        end else if (acc_en) begin
            acc_q      <= ins_acc;
            wcnt_q     <= CW'(base_cnt + CW'(1));
            start_q    <= base_start;
            hold_eop_q <= io.st_eop;
        end
    end

    // Output register; a reload in the same cycle as a transfer keeps it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            out_full_q <= 1'b0;
            frm_cnt    <= '0;
        end else begin
            if (load_out) begin
                out_q      <= cl_word;
                out_full_q <= 1'b1;
            end else if (io.bus_en) begin
                out_full_q <= 1'b0;
            end
            if (frm_done) frm_cnt <= frm_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_st2bus.sv
// Directed bench for st2bus: frames of hand-picked lengths, back-pressure, protocol errors and reset.
module tb_st2bus;
    logic        clk;
    logic        rst_n;
    logic        frm_done;
    logic [15:0] frm_cnt;
    logic        err_sop;
    logic [1:0]  state_dbg;

    st2bus_if #(.ST(24), .BUS(512)) io();

    st2bus dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (io.slave),
        .frm_done  (frm_done),
        .frm_cnt   (frm_cnt),
        .err_sop   (err_sop),
        .state_dbg (state_dbg)
    );

    int compares = 0;
    int fails    = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int ready_low = 0;
    int err_cnt   = 0;
    int bus_bad   = 0;

    logic [511:0] cap_q[$];
    int           cap_cyc_q[$];
    logic         cap_done_q[$];
    logic [511:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && io.bus_en) begin
            cap_q.push_back(io.bus_data);
            cap_cyc_q.push_back(cyc + 1);
            cap_done_q.push_back(frm_done);
        end
        if (rst_n && !io.st_ready) ready_low++;
        if (rst_n && err_sop) err_cnt++;
        if (io.bus_en && !io.bus_ready) bus_bad++;
    end

    function automatic logic [511:0] mk_cl(input logic [7:0] hdr, input int first, input int n);
        logic [511:0] cl;
        cl = '0;
        cl[511:504] = hdr;
        for (int k = 0; k < n; k++) cl[k*24 +: 24] = 24'(first + k);
        return cl;
    endfunction

    // driver tasks
    task automatic drive(input logic [23:0] d, input logic sop, input logic eop);
        int n;
        n = 0;
        io.st_data = d; io.st_valid = 1'b1; io.st_sop = sop; io.st_eop = eop;
        @(negedge clk);
        while (!io.st_ready && n < 200) begin n++; @(negedge clk); end
        if (!io.st_ready) begin
            compares++; fails++;
            $display("FAIL drive_timeout: st_ready stayed 0 for word %h", d);
        end
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        io.st_valid = 1'b0; io.st_sop = 1'b0; io.st_eop = 1'b0;
    endtask

    task automatic send_frame(input int first, input int n);
        for (int i = 0; i < n; i++) drive(24'(first + i), i == 0, i == n - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_q.delete(); cap_cyc_q.delete(); cap_done_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        io.st_data = '0; io.st_valid = 1'b0; io.st_sop = 1'b0; io.st_eop = 1'b0;
        io.bus_ready = 1'b1;
        #13;
        compares++; if (io.st_ready !== 1'b0) begin fails++; $display("FAIL rst_st_ready: got %b want 0", io.st_ready); end
        compares++; if (io.bus_en !== 1'b0) begin fails++; $display("FAIL rst_bus_en: got %b want 0", io.bus_en); end
        compares++; if (io.bus_data !== '0) begin fails++; $display("FAIL rst_bus_data: got %h want 0", io.bus_data); end
        compares++; if (frm_done !== 1'b0) begin fails++; $display("FAIL rst_frm_done: got %b want 0", frm_done); end
        compares++; if (frm_cnt !== 16'd0) begin fails++; $display("FAIL rst_frm_cnt: got %0d want 0", frm_cnt); end
        compares++; if (err_sop !== 1'b0) begin fails++; $display("FAIL rst_err_sop: got %b want 0", err_sop); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        compares++; if (io.st_ready !== 1'b1) begin fails++; $display("FAIL rel_st_ready: got %b want 1", io.st_ready); end
    endtask

    task automatic test_short_frame();
        clear_caps();
        exp_q.push_back(mk_cl(8'hCF, 1, 5));
        send_frame(1, 5);
        idle(4);
        compares++;
        if (cap_q.size() != 1) begin
            fails++; $display("FAIL short_count: got %0d CLs want 1", cap_q.size());
        end else begin
            compares++; if (cap_q[0] !== exp_q[0]) begin fails++; $display("FAIL short_data: got %h want %h", cap_q[0], exp_q[0]); end
            compares++; if (cap_cyc_q[0] != acc_cyc + 1) begin fails++; $display("FAIL short_latency: got cycle %0d want %0d", cap_cyc_q[0], acc_cyc + 1); end
            compares++; if (cap_done_q[0] !== 1'b1) begin fails++; $display("FAIL short_frm_done: got %b want 1", cap_done_q[0]); end
        end
        compares++; if (frm_cnt !== 16'd1) begin fails++; $display("FAIL short_frm_cnt: got %0d want 1", frm_cnt); end
    endtask

    task automatic test_full_cl();
        clear_caps();
        exp_q.push_back(mk_cl(8'hFF, 1, 21));
        ready_low = 0;
        send_frame(1, 21);
        idle(4);
        compares++; if (ready_low != 0) begin fails++; $display("FAIL full_ready: st_ready low %0d cycles want 0", ready_low); end
        compares++;
        if (cap_q.size() != 1) begin
            fails++; $display("FAIL full_count: got %0d CLs want 1", cap_q.size());
        end else begin
            compares++; if (cap_q[0] !== exp_q[0]) begin fails++; $display("FAIL full_data: got %h want %h", cap_q[0], exp_q[0]); end
        end
        compares++; if (frm_cnt !== 16'd2) begin fails++; $display("FAIL full_frm_cnt: got %0d want 2", frm_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_caps();
        exp_q.push_back(mk_cl(8'hBF, 1, 21));
        exp_q.push_back(mk_cl(8'h3F, 22, 21));
        exp_q.push_back(mk_cl(8'h49, 43, 3));
        ready_low = 0;
        send_frame(1, 45);
        idle(4);
        compares++; if (ready_low != 0) begin fails++; $display("FAIL b2b_ready: st_ready low %0d cycles want 0", ready_low); end
        compares++;
        if (cap_q.size() != 3) begin
            fails++; $display("FAIL b2b_count: got %0d CLs want 3", cap_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                compares++;
                if (cap_q[i] !== exp_q[i]) begin fails++; $display("FAIL b2b_data%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
                compares++;
                if (cap_done_q[i] !== (i == 2)) begin fails++; $display("FAIL b2b_done%0d: got %b want %b", i, cap_done_q[i], i == 2); end
            end
        end
        compares++; if (frm_cnt !== 16'd3) begin fails++; $display("FAIL b2b_frm_cnt: got %0d want 3", frm_cnt); end
    endtask

    task automatic test_backpressure();
        clear_caps();
        exp_q.push_back(mk_cl(8'hBF, 1, 21));
        exp_q.push_back(mk_cl(8'h3F, 22, 21));
        exp_q.push_back(mk_cl(8'h49, 43, 3));
        bus_bad = 0;
        io.bus_ready = 1'b0;
        for (int i = 0; i < 42; i++) drive(24'(1 + i), i == 0, 1'b0);
        @(negedge clk);
        compares++; if (io.st_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_ready: got %b want 0", io.st_ready); end
        idle(3);
        compares++; if (io.st_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_ready2: got %b want 0", io.st_ready); end
        compares++; if (cap_q.size() != 0) begin fails++; $display("FAIL bp_no_bus_en: got %0d CLs want 0", cap_q.size()); end
        io.bus_ready = 1'b1;
        drive(24'd43, 1'b0, 1'b0);
        drive(24'd44, 1'b0, 1'b0);
        drive(24'd45, 1'b0, 1'b1);
        idle(5);
        io.bus_ready = 1'b0;
        idle(2);
        compares++; if (bus_bad != 0) begin fails++; $display("FAIL bp_bus_en_gated: %0d cycles with bus_en and no bus_ready, want 0", bus_bad); end
        compares++;
        if (cap_q.size() != 3) begin
            fails++; $display("FAIL bp_count: got %0d CLs want 3", cap_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                compares++;
                if (cap_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_data%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
            end
        end
        compares++; if (frm_cnt !== 16'd4) begin fails++; $display("FAIL bp_frm_cnt: got %0d want 4", frm_cnt); end
        io.bus_ready = 1'b1;
    endtask

    task automatic test_drop_and_err();
        logic [511:0] exp_b;
        clear_caps();
        exp_b = '0;
        exp_b[511:504] = 8'hC6;
        exp_b[23:0]    = 24'hB1;
        exp_b[47:24]   = 24'hB2;
        err_cnt = 0;
        drive(24'h000D01, 1'b0, 1'b0);
        drive(24'h000D02, 1'b0, 1'b1);
        drive(24'h000D03, 1'b0, 1'b0);
        idle(3);
        compares++; if (cap_q.size() != 0) begin fails++; $display("FAIL drop_no_bus_en: got %0d CLs want 0", cap_q.size()); end
        drive(24'hA1, 1'b1, 1'b0);
        drive(24'hA2, 1'b0, 1'b0);
        drive(24'hA3, 1'b0, 1'b0);
        drive(24'hB1, 1'b1, 1'b0);
        drive(24'hB2, 1'b0, 1'b1);
        idle(4);
        compares++; if (err_cnt != 1) begin fails++; $display("FAIL err_pulses: got %0d want 1", err_cnt); end
        compares++;
        if (cap_q.size() != 1) begin
            fails++; $display("FAIL err_count: got %0d CLs want 1", cap_q.size());
        end else begin
            compares++; if (cap_q[0] !== exp_b) begin fails++; $display("FAIL err_data: got %h want %h", cap_q[0], exp_b); end
        end
        compares++; if (frm_cnt !== 16'd5) begin fails++; $display("FAIL err_frm_cnt: got %0d want 5", frm_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_caps();
        for (int i = 0; i < 10; i++) drive(24'(1 + i), i == 0, 1'b0);
        rst_n = 1'b0;
        #1;
        compares++; if (io.st_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready: got %b want 0", io.st_ready); end
        compares++; if (io.bus_en !== 1'b0) begin fails++; $display("FAIL mid_rst_bus_en: got %b want 0", io.bus_en); end
        compares++; if (frm_cnt !== 16'd0) begin fails++; $display("FAIL mid_rst_frm_cnt: got %0d want 0", frm_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 10; i < 21; i++) drive(24'(1 + i), 1'b0, i == 20);
        idle(4);
        compares++; if (cap_q.size() != 0) begin fails++; $display("FAIL mid_no_bus_en: got %0d CLs want 0", cap_q.size()); end
        compares++; if (frm_cnt !== 16'd0) begin fails++; $display("FAIL mid_frm_cnt: got %0d want 0", frm_cnt); end
    endtask

    initial begin
        test_reset();
        test_short_frame();
        test_full_cl();
        test_back_to_back();
        test_backpressure();
        test_drop_and_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end
endmodule

// File: doc/st2bus.md
Name: st2bus

Overview:
- Packs the Avalon-ST output of the turbo decoder into cache-line (CL) buses for write-back to memory; it is the mirror of the input-side bus-to-stream stage.
- Each CL carries a header of BUS_HEAD bits in the top bits, made of flag (2 bits) and length (BUS_HEAD-2 bits), plus a payload of BUS_PAYLOAD bits, packed lowest word first.
- One AFU frame (st_sop..st_eop) becomes one or more CLs, flagged start/body/end.

Parameters:
- BUS, 512, total CL width.
- BUS_HEAD, 8, header width (flag 2 + length BUS_HEAD-2).
- BUS_PAYLOAD, 504, payload width; must equal BUS-BUS_HEAD.
- ST, 24, stream word width; must be a multiple of 8.
- w_frm_cnt, 16, width of the completed-frame counter.
- Derived constants:
  - WPC = BUS_PAYLOAD/ST, words per CL (21 at defaults).
  - BPW = ST/8, bytes per word.
- Legal parameter sets require WPC*BPW <= 2^(BUS_HEAD-2)-1.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- st_data  in  ST  decoded stream word
- st_valid  in  1  word valid
- st_sop  in  1  first word of frame
- st_eop  in  1  last word of frame
- st_ready  out  1  block accepts the word this cycle
- bus_data  out  BUS  CL: header [BUS-1:BUS_PAYLOAD], payload [BUS_PAYLOAD-1:0]
- bus_en  out  1  bus_data valid and transferred this cycle
- bus_ready  in  1  memory side can take a CL
- frm_done  out  1  one-cycle pulse when a CL with the end flag transfers
- frm_cnt  out  w_frm_cnt  count of completed frames, wraps
- err_sop  out  1  one-cycle pulse on a protocol error

Behaviour:
- Clock and reset: one clock. rst_n is asynchronous and active-low; all state clears immediately on assertion.
- Reset values: st_ready=0 while rst_n=0, 1 after release. bus_en=0, bus_data=0, frm_done=0, frm_cnt=0, err_sop=0.
- Accept: a word is accepted when st_valid & st_ready.
- Storage: a word accumulator (ST*WPC bits plus word count wcnt) and a single CL output register (out_full).
- FSM states:
  - S_IDLE: st_ready=1. A non-sop word is dropped silently. A sop word is stored at word 0, the start flag is latched, and the FSM goes to S_FILL.
  - S_FILL: st_ready=1. Word k goes to payload bits [k*ST+ST-1:k*ST].
    - The CL closes on the accepted word when wcnt==WPC-1 or st_eop=1.
    - Header flag: start_latched and eop = 11; start only = 10; eop only = 01; otherwise 00.
    - Length = (words in CL)*BPW bytes.
    - Payload bits above the last word are zero.
  - On close:
    - If out_full=0 or bus_en=1 in that cycle, the CL (including the closing word) loads into the output register at that edge. Next state is S_IDLE if eop, else S_FILL with wcnt=0 and start cleared.
    - Otherwise the CL stays in the accumulator and the FSM goes to S_HOLD.
  - S_HOLD: st_ready=0. When out_full=0 or bus_en=1, the held CL moves to the output register and the FSM goes to S_IDLE or S_FILL by the held flag.
- Output side:
  - bus_en = out_full & bus_ready (combinational from a register and input). bus_en is never 1 while bus_ready=0.
  - bus_data holds the output register and is stable while out_full=1 and bus_ready=0.
  - out_full clears on bus_en unless a reload happens in the same cycle.
- Latency: closing word accepted in cycle t gives bus_en at the earliest in t+1.
- Throughput: with bus_ready=1 throughout, st_ready never deasserts.
- st_sop and st_eop on the same word: single CL, flag 11.
- Frame length an exact multiple of WPC: the last CL is closed by eop with flag 01 and full length. No empty CL is ever emitted.
- Protocol error, sop accepted in S_FILL:
  - err_sop pulses.
  - The partial accumulator is discarded, not emitted.
  - The new frame starts with this word.
  - A CL already in the output register is unaffected.
- frm_done pulses in the cycle bus_en transfers a CL with eop flag set; frm_cnt increments in the same cycle.
- Reset mid-operation: partial and pending CLs are lost; no CL is emitted after release until a new sop.

Test Plan:
1. 5-word frame 0x000001..0x000005 (sop word 1, eop word 5), bus_ready=1 -> one bus_en, 1 cycle after eop; header 0xCF; payload[119:0]=words in order, rest 0; frm_done=1, frm_cnt=1.
2. 21-word frame, bus_ready=1 -> one CL, header 0xFF, payload fully used, st_ready constant 1.
3. 45-word back-to-back frame, bus_ready=1 -> three CLs with headers 0xBF, 0x3F, 0x49; third payload[71:0]=words 43-45, rest 0; st_ready never drops.
4. Same 45-word frame with bus_ready=0 from start -> st_ready drops after word 42 is accepted (S_HOLD); bus_en stays 0. bus_ready=1 for 10 cycles -> three CLs in order, contents identical to scenario 3.
5. Words without sop in S_IDLE -> dropped, no bus_en. Frame A (sop, 3 words), then sop of frame B (2 words, eop) -> err_sop one pulse; only CL 0xC6 carrying B's words emitted.
6. rst_n low for 1 cycle after word 10 of a 21-word frame -> bus_en=0, st_ready=0 asynchronously; after release, remaining non-sop words dropped, frm_cnt=0.
